score_display_ctrl: RTL and testbench



---
 rtl/score_display_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_score_display_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_ctrl.sv
// Score / high-score seven-segment character controller with a sequential binary-to-decimal engine.
// Latency: hex view 1 edge; decimal view S+NUM_DIGITS+2 edges from load (S = decimal digit sum).
// No backpressure: inputs are sampled every cycle; source changes seen mid-conversion are picked up afterwards.
//
// Ports:
//   clk, reset            : system clock, asynchronous active-high reset
//   disp_mode             : 0 = decimal, 1 = hex (applies to score and high score alike)
//   show_high             : single-cycle request to start / retrigger the high-score overlay
//   one_ms_pulse          : 1 ms tick used to time the overlay
//   score, highscore      : binary values to display
//   chars                 : registered 5-bit character codes, digit k at [5k+4:5k], digit 0 rightmost
//   high_active           : overlay in progress
//   dec_busy              : decimal conversion in progress (CONV or DONE)
//   dec_ovf               : last converted value was saturated to all nines
module score_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int SCORE_W    = 24,
    parameter int HOLD_MS    = 3000,
    parameter int LZ_BLANK   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    disp_mode,
    input  logic                    show_high,
    input  logic                    one_ms_pulse,
    input  logic [SCORE_W-1:0]      score,
    input  logic [SCORE_W-1:0]      highscore,
    output logic [5*NUM_DIGITS-1:0] chars,
    output logic                    high_active,
    output logic                    dec_busy,
    output logic                    dec_ovf
);

    localparam int         IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int         CNT_W    = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
    localparam logic [4:0] CH_BLANK = 5'h13;

    // Powers of ten; the table tops out at 10^8 because NUM_DIGITS <= 8.
    function automatic logic [31:0] pow10(input int i);
        case (i)
            0:       pow10 = 32'd1;
            1:       pow10 = 32'd10;
            2:       pow10 = 32'd100;
            3:       pow10 = 32'd1000;
            4:       pow10 = 32'd10000;
            5:       pow10 = 32'd100000;
            6:       pow10 = 32'd1000000;
            7:       pow10 = 32'd10000000;
            8:       pow10 = 32'd100000000;
            default: pow10 = 32'd0;
        endcase
    endfunction

    localparam logic [31:0]      MAX_VAL   = pow10(NUM_DIGITS) - 32'd1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MS - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                        state, state_nxt;
    logic                          do_load, do_sub, do_step, do_done;
    logic [CNT_W-1:0]              ms_cnt;
    logic [SCORE_W-1:0]            src;
    logic [31:0]                   src_ext;
    logic [SCORE_W-1:0]            last;
    logic                          last_sel;
    logic [SCORE_W-1:0]            temp;
    logic [31:0]                   temp_ext;
    logic [31:0]                   pow_cur;
    logic [IDX_W-1:0]              idx;
    logic [NUM_DIGITS-1:0][3:0]    work;
    logic [NUM_DIGITS-1:0][3:0]    disp_buf;
    logic                          ovf_n;
    logic [4*NUM_DIGITS-1:0]       hex_src;
    logic [5*NUM_DIGITS-1:0]       hex_view;
    logic [5*NUM_DIGITS-1:0]       dec_view;
    logic                          lead;

    // ---------------------------------------------------------------- overlay timer
    // A new request always restarts the hold, even on the pulse that would end it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            high_active <= 1'b0;
            ms_cnt      <= '0;
        end else if (show_high) begin
            high_active <= 1'b1;
            ms_cnt      <= '0;
        end else if (high_active && one_ms_pulse) begin
            if (ms_cnt == HOLD_LAST) begin
                high_active <= 1'b0;
                ms_cnt      <= '0;
            end else begin
                ms_cnt <= ms_cnt + CNT_W'(1);
            end
        end
    end

    assign src      = high_active ? highscore : score;
    assign src_ext  = 32'(src);
    assign temp_ext = 32'(temp);
    assign pow_cur  = pow10(int'(idx));

    // ---------------------------------------------------------------- converter FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Reloading also when only the selected source flips keeps the display
    // correct when score and high score happen to hold the same value.
    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_sub    = 1'b0;
        do_step   = 1'b0;
        do_done   = 1'b0;
        case (state)
            IDLE: begin
                if ((src != last) || (high_active != last_sel)) begin
                    do_load   = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (temp_ext >= pow_cur) begin
                    do_sub = 1'b1;
                end else if (idx == '0) begin
                    state_nxt = DONE;
                end else begin
                    do_step = 1'b1;
                end
            end
            DONE: begin
                do_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dec_busy = (state != IDLE);

    // Saturating at 10^N-1 on load guarantees every work digit stays within 0..9.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last     <= '0;
            last_sel <= 1'b0;
            temp     <= '0;
            ovf_n    <= 1'b0;
            idx      <= '0;
            work     <= '0;
            disp_buf <= '0;
            dec_ovf  <= 1'b0;
        end else begin
            if (do_load) begin
                last     <= src;
                last_sel <= high_active;
                temp     <= (src_ext > MAX_VAL) ? SCORE_W'(MAX_VAL) : src;
                ovf_n    <= (src_ext > MAX_VAL);
                work     <= '0;
                idx      <= IDX_W'(NUM_DIGITS - 1);
            end
            if (do_sub) begin
                temp      <= temp - SCORE_W'(pow_cur);
                work[idx] <= work[idx] + 4'd1;
            end
            if (do_step) begin
                idx <= idx - IDX_W'(1);
            end
            if (do_done) begin
                disp_buf <= work;
                dec_ovf  <= ovf_n;
            end
        end
    end

    // ---------------------------------------------------------------- character views
    assign hex_src = (4*NUM_DIGITS)'(src);

    always_comb begin
        hex_view = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            hex_view[5*k +: 5] = {1'b0, hex_src[4*k +: 4]};
        end
    end

    // Walk from the most significant digit down; digits stay blank until the
    // first non-zero one, and digit 0 always ends the blank run.
    always_comb begin
        dec_view = '0;
        lead     = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if ((disp_buf[k] != 4'd0) || (k == 0)) lead = 1'b0;
            if (lead && (LZ_BLANK != 0)) dec_view[5*k +: 5] = CH_BLANK;
            else                         dec_view[5*k +: 5] = {1'b0, disp_buf[k]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) chars <= {NUM_DIGITS{CH_BLANK}};
        else       chars <= disp_mode ? hex_view : dec_view;
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
module tb_score_display_ctrl;

    localparam int          ND   = 6;
    localparam int          SW   = 24;
    localparam int          HOLD = 3;
    localparam int unsigned MAXV = 999999;

    localparam logic [29:0] ALL_BLANK = {6{5'h13}};
    localparam logic [29:0] C_ZERO    = {5'h13, 5'h13, 5'h13, 5'h13, 5'h13, 5'h00};
    localparam logic [29:0] C_SEVEN   = {5'h13, 5'h13, 5'h13, 5'h13, 5'h13, 5'h07};
    localparam logic [29:0] C_42      = {5'h13, 5'h13, 5'h13, 5'h13, 5'h04, 5'h02};
    localparam logic [29:0] C_12345   = {5'h13, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05};
    localparam logic [29:0] C_NINES   = {6{5'h09}};
    localparam logic [29:0] C_ABCDEF  = {5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F};

    logic          clk = 1'b0;
    logic          reset;
    logic          disp_mode;
    logic          show_high;
    logic          one_ms_pulse;
    logic [SW-1:0] score;
    logic [SW-1:0] highscore;
    logic [29:0]   chars;
    logic          high_active;
    logic          dec_busy;
    logic          dec_ovf;

    int n_vec = 0;
    int n_err = 0;

    score_display_ctrl #(
        .NUM_DIGITS (ND),
        .SCORE_W    (SW),
        .HOLD_MS    (HOLD),
        .LZ_BLANK   (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .disp_mode    (disp_mode),
        .show_high    (show_high),
        .one_ms_pulse (one_ms_pulse),
        .score        (score),
        .highscore    (highscore),
        .chars        (chars),
        .high_active  (high_active),
        .dec_busy     (dec_busy),
        .dec_ovf      (dec_ovf)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------ reference model
    // Conversion is modelled as "busy for digit-sum + N + 1 edges, then the
    // saturated value appears in the buffer"; the buffer is kept as a number.
    bit          m_ha;
    int          m_cnt;
    int          m_busy;
    int unsigned m_last;
    bit          m_lsel;
    int unsigned m_buf;
    int unsigned m_pval;
    bit          m_ovf;
    bit          m_povf;
    logic [29:0] m_chars;

    function automatic int unsigned p10(input int k);
        int unsigned r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic int digit_sum(input int unsigned v);
        int s = 0;
        while (v > 0) begin
            s = s + int'(v % 10);
            v = v / 10;
        end
        return s;
    endfunction

    function automatic logic [29:0] dec_chars(input int unsigned v);
        logic [29:0] r;
        int          nd = 1;
        while (nd < ND && v >= p10(nd)) nd++;
        for (int k = 0; k < ND; k++)
            r[5*k +: 5] = (k < nd) ? 5'((v / p10(k)) % 10) : 5'h13;
        return r;
    endfunction

    function automatic logic [29:0] hex_chars(input int unsigned v);
        logic [29:0] r;
        for (int k = 0; k < ND; k++)
            r[5*k +: 5] = 5'((v >> (4*k)) & 32'hF);
        return r;
    endfunction

    task automatic model_reset();
        m_ha = 0; m_cnt = 0; m_busy = 0; m_last = 0; m_lsel = 0;
        m_buf = 0; m_pval = 0; m_ovf = 0; m_povf = 0;
        m_chars = ALL_BLANK;
    endtask

    task automatic model_step();
        int unsigned src;
        int unsigned v;
        logic [29:0] nxt;
        src = m_ha ? int'(highscore) : int'(score);
        nxt = disp_mode ? hex_chars(src) : dec_chars(m_buf);
        if (m_busy == 0) begin
            if (src != m_last || m_ha != m_lsel) begin
                m_last = src;
                m_lsel = m_ha;
                v      = (src > MAXV) ? MAXV : src;
                m_pval = v;
                m_povf = (src > MAXV);
                m_busy = digit_sum(v) + ND + 1;
            end
        end else begin
            m_busy--;
            if (m_busy == 0) begin
                m_buf = m_pval;
                m_ovf = m_povf;
            end
        end
        if (show_high) begin
            m_ha = 1; m_cnt = 0;
        end else if (m_ha && one_ms_pulse) begin
            if (m_cnt == HOLD - 1) begin
                m_ha = 0; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        m_chars = nxt;
    endtask

    // ------------------------------------------------------------ checking
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("chars",       32'(chars),       32'(m_chars));
        chk("high_active", 32'(high_active), 32'(m_ha));
        chk("dec_busy",    32'(dec_busy),    32'(m_busy != 0));
        chk("dec_ovf",     32'(dec_ovf),     32'(m_ovf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_tick();
        one_ms_pulse = 1'b1;
        tick();
        one_ms_pulse = 1'b0;
        tick();
    endtask

    // Called right after tick(): assert between edges, observe, release.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        #1;
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int n;
        bit saw;
        int r;

        reset        = 1'b1;
        disp_mode    = 1'b0;
        show_high    = 1'b0;
        one_ms_pulse = 1'b0;
        score        = '0;
        highscore    = '0;
        model_reset();
        #22;
        compare_all();
        chk("rst_chars", 32'(chars), 32'(ALL_BLANK));
        #1;
        reset = 1'b0;

        // src = 0 right after reset: no load, decimal 0 after one edge
        tick();
        chk("post_rst_zero", 32'(chars), 32'(C_ZERO));
        run(3);

        // decimal 12345: 22 busy cycles, result 23 edges after load
        score = SW'(12345);
        tick();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!dec_busy) break;
            n++;
            tick();
        end
        chk("busy_len_12345", 32'(n), 32'd22);
        tick();
        chk("dec_12345", 32'(chars), 32'(C_12345));
        chk("ovf_12345", 32'(dec_ovf), 32'd0);

        // hex pass-through
        disp_mode = 1'b1;
        score     = SW'(24'hABCDEF);
        tick();
        chk("hex_abcdef", 32'(chars), 32'(C_ABCDEF));
        run(80);

        // overflow saturation, then back to zero
        disp_mode = 1'b0;
        score     = SW'(1048576);
        run(150);
        chk("ovf_nines", 32'(chars), 32'(C_NINES));
        chk("ovf_flag", 32'(dec_ovf), 32'd1);
        score = '0;
        run(150);
        chk("zero_after_ovf", 32'(chars), 32'(C_ZERO));
        chk("ovf_cleared", 32'(dec_ovf), 32'd0);

        // overlay with retrigger: 2 pulses + 3 pulses
        score = SW'(7);
        run(40);
        highscore = SW'(42);
        show_high = 1'b1;
        tick();
        show_high = 1'b0;
        chk("ovl_rise", 32'(high_active), 32'd1);
        run(20);
        chk("ovl_42", 32'(chars), 32'(C_42));
        pulse_tick();
        pulse_tick();
        chk("ovl_2pulses", 32'(high_active), 32'd1);
        show_high = 1'b1;
        tick();
        show_high = 1'b0;
        pulse_tick();
        pulse_tick();
        chk("ovl_4pulses", 32'(high_active), 32'd1);
        pulse_tick();
        chk("ovl_expired", 32'(high_active), 32'd0);
        run(25);
        chk("ovl_back_score", 32'(chars), 32'(C_SEVEN));

        // change during CONV: first result shown, then reload to 7
        score = SW'(999999);
        tick();
        run(5);
        score = SW'(7);
        saw = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (chars == C_NINES) saw = 1;
        end
        chk("mid_saw_999999", 32'(saw), 32'd1);
        chk("mid_end_7", 32'(chars), 32'(C_SEVEN));

        // reset in the middle of a conversion with the overlay active
        highscore = SW'(123456);
        show_high = 1'b1;
        tick();
        show_high = 1'b0;
        run(5);
        chk("pre_rst_busy", 32'(dec_busy), 32'd1);
        async_reset();
        chk("rst_mid_chars", 32'(chars), 32'(ALL_BLANK));
        chk("rst_mid_ha", 32'(high_active), 32'd0);
        chk("rst_mid_busy", 32'(dec_busy), 32'd0);
        tick();
        chk("rst_mid_first", 32'(chars), 32'(C_ZERO));
        run(30);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                if ($urandom_range(0, 2) == 0) score = SW'($urandom());
                else                           score = SW'($urandom_range(0, MAXV));
            end else if (r < 5) begin
                highscore = SW'($urandom_range(0, MAXV));
            end
            show_high    = ($urandom_range(0, 59) == 0);
            one_ms_pulse = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) disp_mode = ~disp_mode;
            tick();
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
